// File: rtl/write_round_robin_arbiter.sv
// write_round_robin_arbiter
//   Round-robin write arbiter: several writers share one downstream buffer.
//   One writer at a time holds the grant.
//   A grant ends when the holder releases its request, or after MAX_BURST
//   forwarded writes. The next holder is chosen in the same cycle, so one
//   grant follows another with no idle cycle in between.
//
// Ports
//   clock               rising-edge clock
//   reset               asynchronous active-high reset
//   request[i]          requester i wants access
//   write_enable[i]     requester i write command (honoured only for the holder)
//   write_data          requester i data in [i*WIDTH +: WIDTH]
//   full[i]             requester i must not write this cycle
//   buffer_write_enable write to downstream buffer
//   buffer_write_data   data to downstream buffer (holder's data, else 0)
//   buffer_full         downstream buffer cannot accept a write
//   grant_valid         a requester holds the grant
//   grant_index         holder index (0 when no grant)

// Per-requester full flag: a requester is blocked unless it holds the grant
// and the buffer can take data.
module write_rr_port_gate #(
    parameter int IW    = 2,
    parameter int INDEX = 0
) (
    input  logic          grant_valid,
    input  logic [IW-1:0] grant_index,
    input  logic          buffer_full,
    output logic          full
);
    assign full = !(grant_valid && (grant_index == IW'(INDEX))) || buffer_full;
endmodule

module write_round_robin_arbiter #(
    parameter int WIDTH      = 8,
    parameter int REQUESTERS = 4,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [REQUESTERS-1:0]         request,
    input  logic [REQUESTERS-1:0]         write_enable,
    input  logic [REQUESTERS*WIDTH-1:0]   write_data,
    output logic [REQUESTERS-1:0]         full,
    output logic                          buffer_write_enable,
    output logic [WIDTH-1:0]              buffer_write_data,
    input  logic                          buffer_full,
    output logic                          grant_valid,
    output logic [$clog2(REQUESTERS)-1:0] grant_index
);
    localparam int IW = $clog2(REQUESTERS);
    localparam int CW = 8;  // holds MAX_BURST-1 for the whole legal range

    typedef enum logic {IDLE, GRANTED} state_t;

    state_t        state, state_nxt;
    logic [IW-1:0] g, g_nxt;          // current holder
    logic [IW-1:0] p, p_nxt;          // round-robin pointer
    logic [CW-1:0] cnt, cnt_nxt;      // writes forwarded in this grant
    logic [IW-1:0] g_inc;             // g+1 modulo REQUESTERS
    logic [IW-1:0] arb_start;
    logic [IW-1:0] sel_idx;
    logic          sel_found;
    logic          fwd;
    logic          burst_done;
    logic          grant_end;

    assign grant_valid = (state == GRANTED);
    assign grant_index = grant_valid ? g : '0;
    assign g_inc       = (g == IW'(REQUESTERS-1)) ? '0 : g + 1'b1;

    assign fwd                 = grant_valid && write_enable[g] && !buffer_full;
    assign buffer_write_enable = fwd;
    assign buffer_write_data   = grant_valid ? write_data[int'(g)*WIDTH +: WIDTH] : '0;

    assign burst_done = fwd && (cnt == CW'(MAX_BURST-1));
    assign grant_end  = grant_valid && (!request[g] || burst_done);

    genvar i;
    generate
        for (i = 0; i < REQUESTERS; i++) begin : g_port
            write_rr_port_gate #(.IW(IW), .INDEX(i)) u_gate (
                .grant_valid (grant_valid),
                .grant_index (g),
                .buffer_full (buffer_full),
                .full        (full[i])
            );
        end
    endgenerate

    // While a grant is running, the search is only used at grant end, and
    // then it starts just after the outgoing holder. While idle it starts at p.
    assign arb_start = grant_valid ? g_inc : p;

    // First requesting index in the order arb_start, arb_start+1, ... (wrapping)
    always_comb begin
        int            j;
        logic [IW-1:0] jj;
        sel_found = 1'b0;
        sel_idx   = '0;
        j         = 0;
        jj        = '0;
        for (int k = 0; k < REQUESTERS; k++) begin
            j = int'(arb_start) + k;
            if (j >= REQUESTERS) j = j - REQUESTERS;
            jj = IW'(j);
            if (!sel_found && request[jj]) begin
                sel_found = 1'b1;
                sel_idx   = jj;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        g_nxt     = g;
        p_nxt     = p;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (sel_found) begin
                    state_nxt = GRANTED;
                    g_nxt     = sel_idx;
                    cnt_nxt   = '0;
                end
            end
            GRANTED: begin
                if (grant_end) begin
                    // The search wraps back to g last. A lone holder whose
                    // burst ran out is therefore granted again.
                    p_nxt   = g_inc;
                    cnt_nxt = '0;
                    if (sel_found) begin
                        g_nxt = sel_idx;
                    end else begin
                        state_nxt = IDLE;
                        g_nxt     = '0;
                    end
                end else if (fwd) begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                g_nxt     = '0;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            g     <= '0;
            p     <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            g     <= g_nxt;
            p     <= p_nxt;
            cnt   <= cnt_nxt;
        end
    end
endmodule

// File: doc/write_round_robin_arbiter.md
WRITE_ROUND_ROBIN_ARBITER -- requirements
Module: write_round_robin_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the data width in bits of every write port.
REQ-002 SHALL have parameter REQUESTERS, default 4, meaning the number of writer ports (legal range 2..16).
REQ-003 SHALL have parameter MAX_BURST, default 4, meaning the maximum writes per grant (legal range 1..255).
REQ-004 SHALL use one clock, and reset SHALL be asynchronous and active-high.
REQ-005 SHALL have port clock, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1, the asynchronous active-high reset.
REQ-007 SHALL have port request, input, REQUESTERS, where bit i means requester i wants access.
REQ-008 SHALL have port write_enable, input, REQUESTERS, the per-requester write command.
REQ-009 SHALL have port write_data, input, REQUESTERS*WIDTH, with requester i's data in bits [i*WIDTH +: WIDTH].
REQ-010 SHALL have port full, output, REQUESTERS, where bit i means requester i must not write this cycle.
REQ-011 SHALL have port buffer_write_enable, output, 1, the write command to the downstream buffer.
REQ-012 SHALL have port buffer_write_data, output, WIDTH, the write data to the downstream buffer.
REQ-013 SHALL have port buffer_full, input, 1, the full flag from the downstream buffer.
REQ-014 SHALL have port grant_valid, output, 1, indicating that a requester currently holds the grant.
REQ-015 SHALL have port grant_index, output, $clog2(REQUESTERS), giving the index of the grant holder (0 when grant_valid is 0).

Function
REQ-016 SHALL implement a two-state FSM: IDLE (no holder) and GRANTED (one holder, registered index g).
REQ-017 SHALL keep a registered round-robin pointer p; the search order is p, p+1, ..., wrapping modulo REQUESTERS.
REQ-018 SHALL, in IDLE with any request bit set, select the first requesting index in search order and register it as g at the next edge (GRANTED), giving one cycle of request-to-grant latency.
REQ-019 SHALL drive full[i] = !(grant_valid && g==i) || buffer_full, combinationally.
REQ-020 SHALL drive buffer_write_enable = grant_valid && write_enable[g] && !buffer_full, so that write_enable from a non-holder, or while buffer_full is high, is ignored and never forwarded.
REQ-021 SHALL drive buffer_write_data = write_data of g when grant_valid is 1, else 0, combinationally with zero added latency.
REQ-022 SHALL keep a burst counter that resets to 0 on each new grant and increments on each forwarded write.
REQ-023 SHALL end the grant in a cycle when request[g] is low, or when a write is forwarded while the counter equals MAX_BURST-1.
REQ-024 SHALL, at grant end, set p to g+1 (modulo REQUESTERS) and, in the same cycle, arbitrate among the current requests starting from g+1, so that the next holder is registered at the next edge with no idle cycle between grants.
REQ-025 SHALL, when the grant ends and no request is set, go to IDLE.
REQ-026 SHALL, when the burst is exhausted and only the holder is requesting, re-grant the same holder with its counter cleared.
REQ-027 SHALL, when request[g] drops in the same cycle as a write_enable from g, forward that write and then end the grant.
REQ-028 SHALL NOT let a change in request bits of non-holders affect the current grant.

Reset
REQ-029 SHALL, while reset is high, set the state to IDLE, p=0, the counter to 0, grant_valid=0, grant_index=0, buffer_write_enable=0, buffer_write_data=0, and full all ones.
REQ-030 SHALL, on reset assertion mid-burst, abort the grant immediately and drop any in-flight write, and after release start arbitration from requester 0.

Verification
REQ-031 SHALL cover a single requester: request[2]=1, then 3 writes 0x11,0x22,0x33 -> grant_index=2 one cycle after request, buffer receives 0x11,0x22,0x33 in order, and full[2]=0 while granted.
REQ-032 SHALL cover all requesters continuous with MAX_BURST=4: request=4'b1111 with writes every cycle -> grants go 0,1,2,3,0, each exactly 4 writes, with no idle cycle between grants.
REQ-033 SHALL cover backpressure: buffer_full=1 during a grant while the holder asserts write_enable -> buffer_write_enable=0, full[g]=1, and the counter unchanged.
REQ-034 SHALL cover early release: the holder drops request after 1 write with requester 3 pending -> requester 3 is granted on the next edge and p=g+1.
REQ-035 SHALL cover an illegal write: requester 1 asserts write_enable with data 0xAA while requester 0 is granted -> 0xAA never appears on buffer_write_data.
REQ-036 SHALL cover reset mid-burst: reset asserted after the 2nd write of a burst -> outputs take their reset values immediately, and after release requester 0 is granted first when all requesters are requesting.
